phy_tx_pattern_gen: RTL and testbench

Transmit-side training pattern generator for the RGMII PHY path. On request, it drives a fixed number of deterministic GMII-byte frames onto the PHY transmit interface. A far-end or loopback receive path uses these frames to sweep and check its input delay taps. It sits between the MAC transmit mux and the RGMII output stage, in the PHY transmit clock domain.

---
 rtl/phy_tx_pattern_gen_if.sv | 34 +++
 rtl/phy_tx_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_phy_tx_pattern_gen.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_pattern_gen_if.sv
// Training-pattern generator control/data bundle: run request/abort in, status and GMII byte stream out.
// Latency: plain wires; the generator registers every output it drives.
// Backpressure: none; the PHY output stage always accepts a byte per clock.
interface phy_tx_pattern_gen_if;
    logic       train_start_in;   // single-cycle run request
    logic       train_abort_in;   // abort current run
    logic       train_busy_out;   // run in progress
    logic       train_done_out;   // one-cycle end-of-run pulse
    logic [7:0] frame_idx_out;    // frame currently being sent
    logic [7:0] phy_txd_out;      // transmit byte
    logic       phy_tvalid_out;   // transmit byte valid

    // Controller side: issues requests, observes the stream.
    modport master (
        output train_start_in,
        output train_abort_in,
        input  train_busy_out,
        input  train_done_out,
        input  frame_idx_out,
        input  phy_txd_out,
        input  phy_tvalid_out
    );

    // Generator side.
    modport slave (
        input  train_start_in,
        input  train_abort_in,
        output train_busy_out,
        output train_done_out,
        output frame_idx_out,
        output phy_txd_out,
        output phy_tvalid_out
    );
endinterface

// File: rtl/phy_tx_pattern_gen.sv
// RGMII TX training pattern generator: FRAME_NUM frames of preamble/SFD/ramp payload/trailer plus IFG.
// Latency: start sampled in cycle T gives the first preamble byte (and busy) in T+1; all outputs registered.
// Backpressure: none; one byte per phy_tx_clk. Ports: phy_tx_clk, sys_rst (sync, active-high), tx_if (slave).
module phy_tx_pattern_gen #(
    parameter int FRAME_NUM   = 16,   // frames per run (1..255)
    parameter int PAYLOAD_LEN = 64,   // payload bytes per frame (4..1024)
    parameter int IFG_LEN     = 12    // idle cycles after each frame (1..255)
) (
    input  logic               phy_tx_clk,
    input  logic               sys_rst,
    phy_tx_pattern_gen_if.slave tx_if
);

    localparam int CW = $clog2(1024) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_PAYLOAD,
        S_TRAILER,
        S_IFG,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      frame_q, frame_d;

    logic [7:0]      txd_q, txd_d;
    logic            tvalid_q, tvalid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state logic. Outputs are then decoded from the *next* state so
    // that, once registered, they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        frame_d = frame_q;

        if (state_q != S_IDLE && tx_if.train_abort_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            frame_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    // Abort in IDLE has no effect of its own but still masks a start.
                    if (tx_if.train_start_in && !tx_if.train_abort_in) begin
                        state_d = S_PREAMBLE;
                        frame_d = '0;
                    end
                end
                S_PREAMBLE: begin
                    if (cnt_q == CW'(6)) begin
                        state_d = S_SFD;
                        cnt_d   = '0;
                    end
                end
                S_SFD: begin
                    state_d = S_PAYLOAD;
                    cnt_d   = '0;
                end
                S_PAYLOAD: begin
                    if (cnt_q == CW'(PAYLOAD_LEN - 1)) begin
                        state_d = S_TRAILER;
                        cnt_d   = '0;
                    end
                end
                S_TRAILER: begin
                    if (cnt_q == CW'(3)) begin
                        state_d = S_IFG;
                        cnt_d   = '0;
                    end
                end
                S_IFG: begin
                    if (cnt_q == CW'(IFG_LEN - 1)) begin
                        cnt_d = '0;
                        if (frame_q == 8'(FRAME_NUM - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_PREAMBLE;
                            frame_d = frame_q + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    frame_d = '0;
                end
            endcase
        end
    end

    // Byte decode for the state being entered.
    always_comb begin
        txd_d    = 8'h00;
        tvalid_d = 1'b0;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        case (state_d)
            S_PREAMBLE: begin
                txd_d    = 8'h55;
                tvalid_d = 1'b1;
            end
            S_SFD: begin
                txd_d    = 8'hD5;
                tvalid_d = 1'b1;
            end
            S_PAYLOAD: begin
                // 8-bit wrapping ramp offset by the frame index.
                txd_d    = frame_d + cnt_d[7:0];
                tvalid_d = 1'b1;
            end
            S_TRAILER: begin
                tvalid_d = 1'b1;
                case (cnt_d[1:0])
                    2'd0:    txd_d = 8'hA5;
                    2'd1:    txd_d = 8'h5A;
                    2'd2:    txd_d = frame_d;
                    default: txd_d = ~frame_d;
                endcase
            end
            default: begin
                txd_d    = 8'h00;
                tvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge phy_tx_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            frame_q  <= '0;
            txd_q    <= 8'h00;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            txd_q    <= txd_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_if.phy_txd_out    = txd_q;
    assign tx_if.phy_tvalid_out = tvalid_q;
    assign tx_if.train_busy_out = busy_q;
    assign tx_if.train_done_out = done_q;
    assign tx_if.frame_idx_out  = frame_q;

endmodule

// File: tb/tb_phy_tx_pattern_gen.sv
// Testbench for phy_tx_pattern_gen: three instances with different frame geometries share one clock/reset.
// Expected streams come from a cycle-offset arithmetic model of the frame layout.
// Stimulus: fixed vector table, hand-written corner sequences, and randomized aborts/stray starts.
module tb_phy_tx_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst;
    logic       start_s  [3];
    logic       abort_s  [3];
    logic [7:0] txd_s    [3];
    logic [7:0] idx_s    [3];
    logic       vld_s    [3];
    logic       busy_s   [3];
    logic       done_s   [3];

    phy_tx_pattern_gen_if ifa();
    phy_tx_pattern_gen_if ifb();
    phy_tx_pattern_gen_if ifc();

    phy_tx_pattern_gen #(.FRAME_NUM(1), .PAYLOAD_LEN(4), .IFG_LEN(2)) dut_a (
        .phy_tx_clk(clk), .sys_rst(sys_rst), .tx_if(ifa));
    phy_tx_pattern_gen #(.FRAME_NUM(16), .PAYLOAD_LEN(64), .IFG_LEN(12)) dut_b (
        .phy_tx_clk(clk), .sys_rst(sys_rst), .tx_if(ifb));
    phy_tx_pattern_gen #(.FRAME_NUM(4), .PAYLOAD_LEN(256), .IFG_LEN(3)) dut_c (
        .phy_tx_clk(clk), .sys_rst(sys_rst), .tx_if(ifc));

    assign ifa.train_start_in = start_s[0];
    assign ifa.train_abort_in = abort_s[0];
    assign ifb.train_start_in = start_s[1];
    assign ifb.train_abort_in = abort_s[1];
    assign ifc.train_start_in = start_s[2];
    assign ifc.train_abort_in = abort_s[2];

    assign txd_s[0] = ifa.phy_txd_out;   assign txd_s[1] = ifb.phy_txd_out;   assign txd_s[2] = ifc.phy_txd_out;
    assign idx_s[0] = ifa.frame_idx_out; assign idx_s[1] = ifb.frame_idx_out; assign idx_s[2] = ifc.frame_idx_out;
    assign vld_s[0] = ifa.phy_tvalid_out; assign vld_s[1] = ifb.phy_tvalid_out; assign vld_s[2] = ifc.phy_tvalid_out;
    assign busy_s[0] = ifa.train_busy_out; assign busy_s[1] = ifb.train_busy_out; assign busy_s[2] = ifc.train_busy_out;
    assign done_s[0] = ifa.train_done_out; assign done_s[1] = ifb.train_done_out; assign done_s[2] = ifc.train_done_out;

    int nf [3];
    int pl [3];
    int ig [3];

    int checks   = 0;
    int failures = 0;
    int cur_t    = 0;
    logic [7:0] cap[$];

    typedef struct packed {
        logic       vld;
        logic       busy;
        logic       done;
        logic [7:0] txd;
        logic [7:0] idx;
    } exp_t;

    typedef struct packed {
        logic [7:0] txd;
        logic       vld;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=0x%0h expected=0x%0h", name, cur_t, act, exp);
        end
    endtask

    // Reference: position within a run derived from the cycle offset since start.
    function automatic exp_t model(input int t, input int n, input int p, input int g);
        exp_t e;
        int per, f, o;
        e   = '0;
        per = 12 + p + g;
        if (t < 1) return e;
        if (t - 1 >= n * per) begin
            if (t - 1 == n * per) begin
                e.busy = 1'b1;
                e.done = 1'b1;
                e.idx  = 8'(n - 1);
            end
            return e;
        end
        f = (t - 1) / per;
        o = (t - 1) % per;
        e.busy = 1'b1;
        e.idx  = 8'(f);
        if (o < 7) begin
            e.vld = 1'b1; e.txd = 8'h55;
        end else if (o == 7) begin
            e.vld = 1'b1; e.txd = 8'hD5;
        end else if (o < 8 + p) begin
            e.vld = 1'b1; e.txd = 8'((f + o - 8) % 256);
        end else if (o < 12 + p) begin
            e.vld = 1'b1;
            case (o - 8 - p)
                0:       e.txd = 8'hA5;
                1:       e.txd = 8'h5A;
                2:       e.txd = 8'(f);
                default: e.txd = ~8'(f);
            endcase
        end
        return e;
    endfunction

    task automatic chk_out(input int k, input exp_t e, input string name);
        chk(name, int'({vld_s[k], busy_s[k], done_s[k], txd_s[k]}),
                  int'({e.vld, e.busy, e.done, e.txd}));
        if (e.busy) chk({name, "_idx"}, int'(idx_s[k]), int'(e.idx));
    endtask

    task automatic chk_idle_all(input string name);
        for (int k = 0; k < 3; k++) begin
            chk_out(k, '0, name);
            chk({name, "_idx"}, int'(idx_s[k]), 0);
        end
    endtask

    // Starts a run on instance k and compares every cycle against the model.
    // abort_t / rst_t interrupt the run at that offset; ign1/ign2 inject stray starts.
    task automatic run_model(input int k, input int abort_t, input int rst_t,
                             input int ign1, input int ign2, input bit rnd,
                             output int busy_cnt);
        int n, p, g, total;
        exp_t e;
        n = nf[k]; p = pl[k]; g = ig[k];
        total    = n * (12 + p + g) + 2;
        busy_cnt = 0;
        cap.delete();
        start_s[k] = 1'b1;
        tick();
        start_s[k] = 1'b0;
        for (int t = 1; t <= total; t++) begin
            cur_t = t;
            e = model(t, n, p, g);
            chk_out(k, e, "run");
            cap.push_back(txd_s[k]);
            if (busy_s[k]) busy_cnt++;
            if (t == abort_t || t == rst_t) begin
                if (t == abort_t) abort_s[k] = 1'b1;
                else              sys_rst    = 1'b1;
                tick();
                abort_s[k] = 1'b0;
                sys_rst    = 1'b0;
                cur_t = t + 1;
                chk_out(k, '0, "interrupt");
                chk("interrupt_idx", int'(idx_s[k]), 0);
                return;
            end
            start_s[k] = (t == ign1 || t == ign2 ||
                          (rnd && e.busy && $urandom_range(0, 7) == 0));
            tick();
        end
        start_s[k] = 1'b0;
    endtask

    initial begin
        int bc;
        int per;

        nf = '{1, 16, 4};
        pl = '{4, 64, 256};
        ig = '{2, 12, 3};

        for (int i = 0; i < 7; i++) vecs[i] = '{8'h55, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{8'hD5, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{8'h01, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{8'h02, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{8'h03, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{8'h5A, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{8'h00, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{8'h00, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{8'h00, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{8'h00, 1'b0, 1'b0, 1'b0};

        // Reset with start held high; nothing may start.
        sys_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b1;
            abort_s[k] = 1'b0;
        end
        repeat (5) tick();
        sys_rst = 1'b0;
        for (int k = 0; k < 3; k++) start_s[k] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            cur_t = c;
            chk_idle_all("reset_idle");
            tick();
        end

        // Single-frame vector table.
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            cur_t = i + 1;
            chk("vec", int'({txd_s[0], vld_s[0], busy_s[0], done_s[0]}), int'(vecs[i]));
            if (busy_s[0]) bc++;
            tick();
        end
        chk("single_busy_cycles", bc, 19);

        // Default run with stray starts in PAYLOAD (t=20) and DONE.
        run_model(1, 0, 0, 20, 16 * 88 + 1, 1'b0, bc);
        chk("default_busy_cycles", bc, 1409);
        chk("f15_payload_first", int'(cap[15 * 88 + 8]),  8'h0F);
        chk("f15_payload_last",  int'(cap[15 * 88 + 71]), 8'h4E);
        chk("f15_trl0", int'(cap[15 * 88 + 72]), 8'hA5);
        chk("f15_trl1", int'(cap[15 * 88 + 73]), 8'h5A);
        chk("f15_trl2", int'(cap[15 * 88 + 74]), 8'h0F);
        chk("f15_trl3", int'(cap[15 * 88 + 75]), 8'hF0);

        // Payload wrap: frame 3 byte 253 of a 256-byte payload.
        run_model(2, 0, 0, 0, 0, 1'b0, bc);
        per = 12 + 256 + 3;
        chk("wrap_f3_b253", int'(cap[3 * per + 8 + 253]), 8'h00);
        chk("wrap_busy_cycles", bc, 4 * per + 1);

        // Abort in the 20th byte of frame 2, then a fresh run right away.
        run_model(1, 2 * 88 + 20, 0, 0, 0, 1'b0, bc);
        run_model(1, 0, 0, 0, 0, 1'b0, bc);
        chk("after_abort_busy_cycles", bc, 1409);

        // Simultaneous start and abort in IDLE.
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cur_t = c;
            chk_out(0, '0, "start_abort_idle");
            tick();
        end

        // Reset during the trailer of frame 5, then a normal run.
        run_model(1, 0, 5 * 88 + 74, 0, 0, 1'b0, bc);
        chk_idle_all("mid_reset");
        run_model(1, 0, 0, 0, 0, 1'b0, bc);
        chk("after_reset_busy_cycles", bc, 1409);

        // Randomized runs: random instance, random abort point, random stray starts.
        for (int r = 0; r < 8; r++) begin
            int k, at, n_per;
            k     = int'($urandom_range(0, 2));
            n_per = nf[k] * (12 + pl[k] + ig[k]);
            at    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n_per + 1)) : 0;
            run_model(k, at, 0, 0, 0, 1'b1, bc);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
